decode_stage: RTL and testbench

Registered, parametrised RV32I/RV64I decode pipeline stage sitting between fetch and register-read/issue. Decodes a 32-bit instruction into register indices, function fields, an XLEN-wide sign-extended immediate, a format class and usage flags. The stage uses a valid/ready handshake with a two-entry skid buffer. It sustains one instruction per cycle under back-pressure and supports pipeline flush.

---
 rtl/decode_pkg.sv | 55 +++++
 rtl/decode_comb.sv | 79 +++++++
 rtl/decode_stage.sv | 99 +++++++++
 tb/tb_decode_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types for the RV32I/RV64I decode stage: format classes, opcodes, decoded record.
package decode_pkg;

    typedef enum logic [2:0] {
        T_NONE = 3'd0,
        T_U    = 3'd1,
        T_J    = 3'd2,
        T_B    = 3'd3,
        T_I    = 3'd4,
        T_S    = 3'd5,
        T_R    = 3'd6
    } instr_type_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Immediate is held outside this record because its width follows XLEN.
    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        instr_type_e itype;
        logic        rd_we;
        logic        rs1_used;
        logic        rs2_used;
        logic        illegal;
    } decoded_t;

    function automatic instr_type_e classify(input logic [6:0] op);
        instr_type_e t;
        case (op)
            OP_LUI, OP_AUIPC:                               t = T_U;
            OP_JAL:                                         t = T_J;
            OP_BRANCH:                                      t = T_B;
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:  t = T_I;
            OP_STORE:                                       t = T_S;
            OP_REG:                                         t = T_R;
            default:                                        t = T_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational instruction -> decoded record + XLEN-wide sign-extended immediate.
// Optional illegal-encoding detection when DECODE_ILLEGAL_CHECK_EN is defined.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output decoded_t        dec,
    output logic [XLEN-1:0] imm
);

    instr_type_e t;
    logic [31:0] imm32;

    always_comb begin
        t     = classify(instr[6:0]);
        dec   = '0;
        imm32 = '0;
        dec.itype = t;
        if (t != T_NONE) begin
            dec.op = instr[6:0];
        end
        case (t)
            T_U: begin
                dec.rd = instr[11:7];
                imm32  = {instr[31:12], 12'h000};
            end
            T_J: begin
                dec.rd = instr[11:7];
                imm32  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            T_B: begin
                dec.funct3   = instr[14:12];
                dec.rs1      = instr[19:15];
                dec.rs2      = instr[24:20];
                dec.rs1_used = 1'b1;
                dec.rs2_used = 1'b1;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            T_I: begin
                dec.rd       = instr[11:7];
                dec.funct3   = instr[14:12];
                dec.rs1      = instr[19:15];
                dec.rs1_used = 1'b1;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            T_S: begin
                dec.funct3   = instr[14:12];
                dec.rs1      = instr[19:15];
                dec.rs2      = instr[24:20];
                dec.rs1_used = 1'b1;
                dec.rs2_used = 1'b1;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            T_R: begin
                dec.rd       = instr[11:7];
                dec.funct3   = instr[14:12];
                dec.rs1      = instr[19:15];
                dec.rs2      = instr[24:20];
                dec.funct7   = instr[31:25];
                dec.rs1_used = 1'b1;
                dec.rs2_used = 1'b1;
            end
            default: ;
        endcase
        dec.rd_we = (t == T_U || t == T_J || t == T_I || t == T_R) && (dec.rd != 5'd0);
`ifdef DECODE_ILLEGAL_CHECK_EN
        // RV64 shift amounts are 6 bits wide, so only instr[31:26] must be clear.
        dec.illegal = (instr[1:0] != 2'b11)
                   || (t == T_NONE)
                   || (t == T_R && !(instr[31:25] inside {7'b0000000, 7'b0100000, 7'b0000001}))
                   || (instr[6:0] == OP_IMM && instr[14:12] == 3'b001 &&
                       ((XLEN == 64) ? (instr[31:26] != 6'd0) : (instr[31:25] != 7'd0)));
`endif
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: main + skid entry, 1-cycle latency, full rate under back-pressure.
// in_ready is registered (skid empty); flush/reset clear both entries. Macro: DECODE_ILLEGAL_CHECK_EN.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_op,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_rd_we,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_illegal
);

    decoded_t        dec_in;
    logic [XLEN-1:0] imm_in;

    decoded_t        main_dat, skid_dat;
    logic [XLEN-1:0] main_imm, skid_imm;
    logic [PC_W-1:0] main_pc, skid_pc;
    logic            main_vld, skid_vld;

    logic accept, advance, skid_nxt;

    decode_comb #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .dec   (dec_in),
        .imm   (imm_in)
    );

    assign accept  = in_valid && in_ready;
    assign advance = !main_vld || out_ready;
    // Skid only fills while main is stalled; it cannot accept when already full.
    assign skid_nxt = !advance && (skid_vld || accept);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            in_ready <= 1'b1;
            main_dat <= '0;
            main_imm <= '0;
            main_pc  <= '0;
        end else begin
            in_ready <= !skid_nxt;
            skid_vld <= skid_nxt;
            if (advance) begin
                main_vld <= skid_vld || accept;
                if (skid_vld) begin
                    main_dat <= skid_dat;
                    main_imm <= skid_imm;
                    main_pc  <= skid_pc;
                end else if (accept) begin
                    main_dat <= dec_in;
                    main_imm <= imm_in;
                    main_pc  <= in_pc;
                end
            end else if (accept) begin
                skid_dat <= dec_in;
                skid_imm <= imm_in;
                skid_pc  <= in_pc;
            end
        end
    end

    assign out_valid    = main_vld;
    assign out_pc       = main_pc;
    assign out_op       = main_dat.op;
    assign out_funct3   = main_dat.funct3;
    assign out_funct7   = main_dat.funct7;
    assign out_rd       = main_dat.rd;
    assign out_rs1      = main_dat.rs1;
    assign out_rs2      = main_dat.rs2;
    assign out_imm      = main_imm;
    assign out_type     = main_dat.itype;
    assign out_rd_we    = main_dat.rd_we;
    assign out_rs1_used = main_dat.rs1_used;
    assign out_rs2_used = main_dat.rs2_used;
    assign out_illegal  = main_dat.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, skid back-pressure, flush and reset.
module tb_decode_stage;

    localparam int XLEN = 32;
    localparam int PC_W = 32;
`ifdef DECODE_ILLEGAL_CHECK_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, out_ready;
    logic            in_ready, out_valid;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc, out_pc;
    logic [6:0]      out_op, out_funct7;
    logic [2:0]      out_funct3, out_type;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic [XLEN-1:0] out_imm;
    logic            out_rd_we, out_rs1_used, out_rs2_used, out_illegal;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_op       (out_op),
        .out_funct3   (out_funct3),
        .out_funct7   (out_funct7),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_imm      (out_imm),
        .out_type     (out_type),
        .out_rd_we    (out_rd_we),
        .out_rs1_used (out_rs1_used),
        .out_rs2_used (out_rs2_used),
        .out_illegal  (out_illegal)
    );

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic [31:0] pc, input logic [2:0] typ,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [XLEN-1:0] imm,
                           input logic rdwe, input logic r1u, input logic r2u, input logic ill);
        chk({tag, ".valid"},  64'(out_valid),    64'd1);
        chk({tag, ".pc"},     64'(out_pc),       64'(pc));
        chk({tag, ".type"},   64'(out_type),     64'(typ));
        chk({tag, ".rd"},     64'(out_rd),       64'(rd));
        chk({tag, ".rs1"},    64'(out_rs1),      64'(rs1));
        chk({tag, ".rs2"},    64'(out_rs2),      64'(rs2));
        chk({tag, ".funct3"}, 64'(out_funct3),   64'(f3));
        chk({tag, ".funct7"}, 64'(out_funct7),   64'(f7));
        chk({tag, ".imm"},    64'(out_imm),      64'(imm));
        chk({tag, ".rd_we"},  64'(out_rd_we),    64'(rdwe));
        chk({tag, ".rs1u"},   64'(out_rs1_used), 64'(r1u));
        chk({tag, ".rs2u"},   64'(out_rs2_used), 64'(r2u));
        chk({tag, ".ill"},    64'(out_illegal),  64'(ill));
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step; step;
        reset = 1'b0;
        chk("rst.valid", 64'(out_valid),   64'd0);
        chk("rst.ready", 64'(in_ready),    64'd1);
        chk("rst.type",  64'(out_type),    64'd0);
        chk("rst.imm",   64'(out_imm),     64'd0);
        chk("rst.rd",    64'(out_rd),      64'd0);
        chk("rst.pc",    64'(out_pc),      64'd0);
        chk("rst.ill",   64'(out_illegal), 64'd0);

        // Full-rate stream of distinct formats, one check per cycle.
        drive(1'b1, 32'h123450B7, 32'h100); step;
        chk_dec("lui", 32'h100, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, sx(32'h12345000), 1, 0, 0, 0);
        drive(1'b1, 32'hFFF00093, 32'h104); step;
        chk_dec("addi_m1", 32'h104, 3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, sx(32'hFFFFFFFF), 1, 1, 0, 0);
        drive(1'b1, 32'h00000013, 32'h108); step;
        chk_dec("nop", 32'h108, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, sx(32'h0), 0, 1, 0, 0);
        drive(1'b1, 32'h0000007F, 32'h10C); step;
        chk("bad.valid", 64'(out_valid),   64'd1);
        chk("bad.type",  64'(out_type),    64'd0);
        chk("bad.rd",    64'(out_rd),      64'd0);
        chk("bad.imm",   64'(out_imm),     64'd0);
        chk("bad.ill",   64'(out_illegal), 64'(ILL_EN));
        drive(1'b1, 32'h02208033, 32'h110); step;
        chk_dec("mul", 32'h110, 3'd6, 5'd0, 5'd1, 5'd2, 3'd0, 7'h01, sx(32'h0), 0, 1, 1, 0);
        drive(1'b1, 32'hFE208033, 32'h114); step;
        chk_dec("r_f7bad", 32'h114, 3'd6, 5'd0, 5'd1, 5'd2, 3'd0, 7'h7F, sx(32'h0), 0, 1, 1, ILL_EN);
        drive(1'b1, 32'hFE20AE23, 32'h118); step;
        chk_dec("sw", 32'h118, 3'd5, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, sx(32'hFFFFFFFC), 0, 1, 1, 0);
        drive(1'b1, 32'hFE208CE3, 32'h11C); step;
        chk_dec("beq", 32'h11C, 3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, sx(32'hFFFFFFF8), 0, 1, 1, 0);
        drive(1'b1, 32'h008000EF, 32'h120); step;
        chk_dec("jal", 32'h120, 3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, sx(32'h8), 1, 0, 0, 0);
        drive(1'b0, 32'h0, 32'h0); step;
        chk("idle.valid", 64'(out_valid), 64'd0);

        // Back-pressure: two stalled cycles, then release.
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h200); step;
        chk("bp0.valid", 64'(out_valid), 64'd1);
        chk("bp0.pc",    64'(out_pc),    64'h200);
        chk("bp0.ready", 64'(in_ready),  64'd1);
        drive(1'b1, 32'h00200113, 32'h204); step;
        chk("bp1.pc",    64'(out_pc),    64'h200);
        chk("bp1.rd",    64'(out_rd),    64'd1);
        chk("bp1.ready", 64'(in_ready),  64'd0);
        out_ready = 1'b1;
        drive(1'b1, 32'h00300193, 32'h208); step;
        chk("bp2.pc",    64'(out_pc),    64'h204);
        chk("bp2.rd",    64'(out_rd),    64'd2);
        chk("bp2.ready", 64'(in_ready),  64'd1);
        step;
        chk("bp3.pc",    64'(out_pc),    64'h208);
        chk("bp3.rd",    64'(out_rd),    64'd3);
        drive(1'b1, 32'h00400213, 32'h20C); step;
        chk("bp4.pc",    64'(out_pc),    64'h20C);
        chk("bp4.imm",   64'(out_imm),   64'd4);
        drive(1'b0, 32'h0, 32'h0); step;
        chk("bp5.valid", 64'(out_valid), 64'd0);

        // Flush with both entries occupied and a pending input.
        out_ready = 1'b0;
        drive(1'b1, 32'h00500293, 32'h300); step;
        drive(1'b1, 32'h00600313, 32'h304); step;
        chk("fl0.ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h00700393, 32'h308); step;
        flush = 1'b0;
        chk("fl1.valid", 64'(out_valid), 64'd0);
        chk("fl1.ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0); step;
        chk("fl2.valid", 64'(out_valid), 64'd0);

        // Flush in a cycle that accepts: input must be dropped.
        flush = 1'b1;
        drive(1'b1, 32'h00800413, 32'h310); step;
        flush = 1'b0;
        chk("fl3.valid", 64'(out_valid), 64'd0);
        drive(1'b0, 32'h0, 32'h0); step;
        chk("fl4.valid", 64'(out_valid), 64'd0);

        // Reset mid-stream behaves like flush and clears data fields.
        out_ready = 1'b0;
        drive(1'b1, 32'h00900493, 32'h400); step;
        drive(1'b1, 32'h00A00513, 32'h404); step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("rs.valid", 64'(out_valid), 64'd0);
        chk("rs.ready", 64'(in_ready),  64'd1);
        chk("rs.pc",    64'(out_pc),    64'd0);
        chk("rs.type",  64'(out_type),  64'd0);
        out_ready = 1'b1;
        step;
        chk("rs2.valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
